mat_trisolve: RTL and testbench
===============================

// Module: mat_trisolve
// PURPOSE
//  Solves triangular system L*x = y for x: the inverse of matrix-vector multiply.
//  Serial forward substitution with one shared smul; start/busy/done handshake.
//  Sits beside the parallel multiplier in matrix pipelines (e.g. after a
//  Cholesky/LU stage) where area beats latency.
// PARAMETERS
//  N  3  matrix order (rows = cols of L, length of y and x); N >= 1
// PORTS
//  g.clk     in   1          clock (carried in fixedp interface g)
//  g.reset   in   1          synchronous active-high reset (carried in g)
//  g         --   iface      fixedp parameters: g.WIDTH, g.ZERO; shared by smul
//  l         in   [N:1][N:1][g.WIDTH-1:0]  triangular matrix L, l[row][col]
//  inv_diag  in   [N:1][g.WIDTH-1:0]       1/L[i][i], precomputed by caller
//  y         in   [N:1][g.WIDTH-1:0]       right-hand side
//  start     in   1          request; honoured only in IDLE
//  busy      out  1          solve in progress
//  done      out  1          one-cycle pulse, x valid from this cycle
//  x         out  [N:1][g.WIDTH-1:0]       solution; held until next done
// BEHAVIOUR
//  - Reset: state IDLE, busy=0, done=0, every x[i]=g.ZERO, internal regs cleared.
//    Reset mid-solve aborts immediately; no done pulse, x forced to g.ZERO.
//  - IDLE: start=1 latches l, inv_diag, y into internal regs; row i=1, j=1,
//    acc=y[1]. Inputs may change freely after that cycle.
//  - MAC (row i, j<i): acc <= acc - smul(l[i][j], xr[j]); j++. At j=i -> SCALE.
//  - SCALE: xr[i] <= smul(acc, inv_diag[i]). If i==N -> DONE, else i++, j=1,
//    acc=y[i+1]; row with i=1 goes straight to SCALE.
//  - DONE: x <= xr, done=1, busy=0, -> IDLE. Next start accepted the cycle
//    after done (start high during DONE is ignored).
//  - Timing: start in cycle 0; busy=1 cycles 1..T, T=N(N+1)/2; done=1 and x
//    updated in cycle T+1 (N=3 -> done in cycle 7). x never changes mid-solve.
//  - start while busy: ignored, no effect on operands or timing.
//  - smul used combinationally, one product per cycle. Add/sub wrap modulo
//    2^g.WIDTH, no saturation; overflow is silent.
//  - Entries above diagonal of l (and the diagonal itself) never read in
//    lower mode; inv_diag=ZERO yields x[i]=ZERO, no error flag.
// CONFIGURATION
//  MAT_TRISOLVE_UPPER_EN defined: adds input port `upper` (1 bit, sampled with
//   start). upper=1 -> back substitution: rows N..1, j runs i+1..N, reads only
//   strictly-upper entries; same cycle count T. upper=0 -> lower as above.
//  Not defined: no `upper` port; lower-triangular only.
// TESTING (N=3, values in fixed-point units, 1.0 = fixedp one)
//  1 Reset held 3 cycles, start=1 throughout -> busy=0, done=0, x all ZERO.
//  2 L=I, inv_diag=[1,1,1], y=[1,2,3], start cycle 0 -> busy cycles 1..6,
//    done cycle 7 only, x=[1,2,3].
//  3 L=[[2,0,0],[1,4,0],[2,1,1]], inv_diag=[0.5,0.25,1], y=[2,5,7]
//    -> x=[1,1,4]; junk in upper triangle of l does not change result.
//  4 start pulsed cycle 3 during solve of test 3, inputs changed cycle 1
//    -> same x, done still cycle 7; back-to-back start cycle 8 -> done cycle 15.
//  5 reset asserted cycle 4 mid-solve -> busy=0 cycle 5, no done, x=ZERO;
//    fresh start afterwards completes normally.
//  6 (UPPER_EN) upper=1, U=[[1,2,0],[0,1,3],[0,0,2]], inv_diag=[1,1,0.5],
//    y=[5,7,4] -> done cycle 7, x=[3,1,2].

Source files
------------

// File: rtl/mat_trisolve_if.sv
// Fixed-point context shared by arithmetic blocks: word width, binary point
// position and the encoding of zero, plus the clock/reset they run on.
interface fixedp #(
  parameter int WIDTH = 16,
  parameter int FRAC = 8,
  parameter logic [WIDTH-1:0] ZERO = '0
) (
  input logic clk,
  input logic reset
);
  modport slave (input clk, input reset);
endinterface

// File: rtl/mat_trisolve.sv
// Serial triangular solver L*x = y using one shared fixed-point multiplier.
// Define MAT_TRISOLVE_UPPER_EN to add the `upper` port (back substitution).
module mat_trisolve #(
  parameter int N = 3
) (
  fixedp.slave g,
`ifdef MAT_TRISOLVE_UPPER_EN
  input logic upper,
`endif
  input logic [N:1][N:1][g.WIDTH-1:0] l,
  input logic [N:1][g.WIDTH-1:0] inv_diag,
  input logic [N:1][g.WIDTH-1:0] y,
  input logic start,
  output logic busy,
  output logic done,
  output logic [N:1][g.WIDTH-1:0] x
);
  localparam int W = g.WIDTH;
  localparam int F = g.FRAC;
  localparam int IW = (N < 2) ? 1 : $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, MAC, SCALE, DONE} state_t;

  function automatic logic [W-1:0] smul(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    return W'(((2*W)'($signed(a)) * (2*W)'($signed(b))) >>> F);
  endfunction

  state_t state;
  logic [N:1][N:1][W-1:0] lr;
  logic [N:1][W-1:0] dr;
  logic [N:1][W-1:0] yr;
  logic [N:1][W-1:0] xr;
  logic [W-1:0] acc;
  logic [IW-1:0] i;
  logic [IW-1:0] j;
  logic up;

  logic [W-1:0] ma;
  logic [W-1:0] mb;
  logic [W-1:0] prod;
  logic [IW-1:0] nxt_i;
  logic last_row;
  logic mac_last;

`ifndef MAT_TRISOLVE_UPPER_EN
  assign up = 1'b0;
`endif

  // The single multiplier serves MAC and SCALE on alternate operands.
  always_comb begin
    ma = lr[i][j];
    mb = xr[j];
    if (state == SCALE) begin
      ma = acc;
      mb = dr[i];
    end
    prod = smul(ma, mb);
    nxt_i = up ? (i - IW'(1)) : (i + IW'(1));
    last_row = up ? (i == IW'(1)) : (i == IW'(N));
    mac_last = up ? (j == IW'(N)) : ((j + IW'(1)) == i);
  end

  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      x <= {N{g.ZERO}};
      lr <= '0;
      dr <= '0;
      yr <= '0;
      xr <= '0;
      acc <= '0;
      i <= IW'(1);
      j <= IW'(1);
`ifdef MAT_TRISOLVE_UPPER_EN
      up <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lr <= l;
            dr <= inv_diag;
            yr <= y;
            busy <= 1'b1;
            state <= SCALE;
`ifdef MAT_TRISOLVE_UPPER_EN
            up <= upper;
            i <= upper ? IW'(N) : IW'(1);
            j <= upper ? IW'(N) : IW'(1);
            acc <= upper ? y[N] : y[1];
`else
            i <= IW'(1);
            j <= IW'(1);
            acc <= y[1];
`endif
          end
        end
        MAC: begin
          acc <= acc - prod;
          j <= j + IW'(1);
          if (mac_last) state <= SCALE;
        end
        SCALE: begin
          xr[i] <= prod;
          if (last_row) begin
            x <= xr;
            x[i] <= prod;
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end else begin
            i <= nxt_i;
            j <= up ? i : IW'(1);
            acc <= yr[nxt_i];
            state <= MAC;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_trisolve.sv
// Randomized scoreboard bench for mat_trisolve (N=3, Q8.8 fixed point).
module tb_mat_trisolve;
  localparam int N = 3;
  localparam int W = 16;
  localparam int F = 8;
  localparam int T = N * (N + 1) / 2;

  typedef logic [N:1][N:1][W-1:0] mat_t;
  typedef logic [N:1][W-1:0] vec_t;
  typedef struct {
    vec_t x;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic upper = 1'b0;
  mat_t l = '0;
  vec_t inv_diag = '0;
  vec_t y = '0;
  vec_t x;
  logic busy;
  logic done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int win_s = -100;
  bit track = 1'b0;
  vec_t last_x = '0;
  exp_t exp_q[$];
  exp_t e;

  fixedp #(.WIDTH(W), .FRAC(F)) g (.clk(clk), .reset(reset));

  mat_trisolve #(.N(N)) dut (
    .g(g),
`ifdef MAT_TRISOLVE_UPPER_EN
    .upper(upper),
`endif
    .l(l),
    .inv_diag(inv_diag),
    .y(y),
    .start(start),
    .busy(busy),
    .done(done),
    .x(x)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] smul_ref(logic [W-1:0] a, logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return W'(p >>> F);
  endfunction

  // Forward (or back) substitution straight from the defining equations.
  function automatic vec_t ref_solve(mat_t m, vec_t d, vec_t r, logic up);
    vec_t xs;
    logic [W-1:0] a;
    xs = '0;
    if (!up) begin
      for (int i = 1; i <= N; i++) begin
        a = r[i];
        for (int k = 1; k < i; k++) a = a - smul_ref(m[i][k], xs[k]);
        xs[i] = smul_ref(a, d[i]);
      end
    end else begin
      for (int i = N; i >= 1; i--) begin
        a = r[i];
        for (int k = i + 1; k <= N; k++) a = a - smul_ref(m[i][k], xs[k]);
        xs[i] = smul_ref(a, d[i]);
      end
    end
    return xs;
  endfunction

  task automatic chk_bit(string name, logic act, logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %b want %b", name, cyc, act, want);
    end
  endtask

  task automatic chk_int(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc, act, want);
    end
  endtask

  task automatic chk_vec(string name, vec_t act, vec_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, want);
    end
  endtask

  task automatic scramble();
    for (int r = 1; r <= N; r++) begin
      for (int c = 1; c <= N; c++) l[r][c] = W'($urandom);
      inv_diag[r] = W'($urandom);
      y[r] = W'($urandom);
    end
    upper = 1'($urandom);
  endtask

  // Monitor: pops the scoreboard on done, checks busy window and x hold.
  always @(negedge clk) begin
    if (!reset && track) begin
      chk_bit("busy", busy, (cyc >= win_s + 1) && (cyc <= win_s + T));
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done cyc=%0d got x=%h want no done", cyc, x);
        end else begin
          e = exp_q.pop_front();
          chk_int("done_cycle", cyc, e.cyc);
          chk_vec("x", x, e.x);
        end
      end else begin
        chk_vec("x_hold", x, last_x);
      end
      last_x = x;
    end
  end

  // poke: cycle offset of a stray start while busy (0 = none);
  // hold_done: raise start during the done cycle, which must be ignored.
  task automatic run_solve(mat_t m, vec_t d, vec_t r, logic up,
                           int poke, bit hold_done);
    int s;
    int n;
    exp_t ex;
    @(negedge clk);
    n = 0;
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    l = m;
    inv_diag = d;
    y = r;
    upper = up;
    start = 1'b1;
    s = cyc;
    win_s = s;
    ex.x = ref_solve(m, d, r, up);
    ex.cyc = s + T + 1;
    exp_q.push_back(ex);
    @(negedge clk);
    start = 1'b0;
    scramble();
    if (poke > 1) begin
      repeat (poke - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 4 * T) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout cyc=%0d got no done want done at %0d", cyc, s + T + 1);
      exp_q.delete();
    end
    if (hold_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got hang want finish", cyc);
    $fatal(1);
  end

  initial begin
    mat_t m;
    vec_t d;
    vec_t r;
    int s;

    // Reset held with start asserted.
    reset = 1'b1;
    start = 1'b1;
    scramble();
    upper = 1'b0;
    repeat (3) @(negedge clk);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_vec("rst_x", x, '0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk_bit("idle_busy", busy, 1'b0);
    last_x = '0;
    win_s = -100;
    track = 1'b1;

    // Identity.
    m = '0;
    for (int i = 1; i <= N; i++) begin
      m[i][i] = 16'h0100;
      d[i] = 16'h0100;
      r[i] = W'(i * 256);
    end
    run_solve(m, d, r, 1'b0, 0, 1'b0);

    // Worked example with junk above the diagonal.
    m[1] = {16'h7777, 16'h1234, 16'h0200};
    m[2] = {16'hbeef, 16'h0400, 16'h0100};
    m[3] = {16'h0100, 16'h0100, 16'h0200};
    d = {16'h0100, 16'h0040, 16'h0080};
    r = {16'h0700, 16'h0500, 16'h0200};
    run_solve(m, d, r, 1'b0, 3, 1'b0);
    // Back-to-back, then start held during the done cycle.
    run_solve(m, d, r, 1'b0, 0, 1'b1);
    run_solve(m, d, r, 1'b0, 0, 1'b0);

    // Zero reciprocal diagonal gives zero solution.
    d = '0;
    run_solve(m, d, r, 1'b0, 0, 1'b0);

    // Reset mid-solve aborts.
    @(negedge clk);
    while (busy || done) @(negedge clk);
    d = {16'h0100, 16'h0040, 16'h0080};
    l = m;
    inv_diag = d;
    y = r;
    upper = 1'b0;
    start = 1'b1;
    s = cyc;
    win_s = s;
    @(negedge clk);
    start = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    track = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_int("abort_cycle", cyc, s + 5);
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_done", done, 1'b0);
    chk_vec("abort_x", x, '0);
    reset = 1'b0;
    last_x = '0;
    win_s = -100;
    track = 1'b1;
    run_solve(m, d, r, 1'b0, 0, 1'b0);

`ifdef MAT_TRISOLVE_UPPER_EN
    m[1] = {16'h0000, 16'h0200, 16'h0100};
    m[2] = {16'h0300, 16'h0100, 16'h0000};
    m[3] = {16'h0200, 16'h0000, 16'h0000};
    d = {16'h0080, 16'h0100, 16'h0100};
    r = {16'h0400, 16'h0700, 16'h0500};
    run_solve(m, d, r, 1'b1, 0, 1'b0);
`endif

    // Randomized solves.
    for (int k = 0; k < 30; k++) begin
      for (int i = 1; i <= N; i++) begin
        for (int c = 1; c <= N; c++) m[i][c] = W'($urandom);
        d[i] = W'($urandom);
        r[i] = W'($urandom);
      end
`ifdef MAT_TRISOLVE_UPPER_EN
      run_solve(m, d, r, 1'($urandom), int'($urandom_range(0, T)),
                1'($urandom));
`else
      run_solve(m, d, r, 1'b0, int'($urandom_range(0, T)), 1'($urandom));
`endif
    end

    repeat (4) @(negedge clk);
    chk_int("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
